// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared constants and types for the reorder buffer
//
// Purpose : sizing constants and the entry / pointer types used by rob,
//           rob_ptr and rob_if.
// Contents: ROB_IDX_WIDTH, XLEN, DEPTH, RD_WIDTH, rob_entry_t, rob_ptr_t.
package rob_pkg;

   localparam int ROB_IDX_WIDTH = 5;
   localparam int XLEN          = 32;
   localparam int DEPTH         = 2 ** ROB_IDX_WIDTH;
   localparam int RD_WIDTH      = 5;

   typedef struct packed {
      logic                valid;
      logic                done;
      logic [RD_WIDTH-1:0] rd;
      logic [XLEN-1:0]     data;
   } rob_entry_t;

   // Extra MSB distinguishes a full buffer from an empty one when the
   // index bits of head and tail coincide.
   typedef struct packed {
      logic                     wrap;
      logic [ROB_IDX_WIDTH-1:0] idx;
   } rob_ptr_t;

endpackage

// File: rtl/rob_if.sv
// rtl/rob_if.sv - dispatch / CDB / commit bundle of the reorder buffer
//
// Purpose : groups every non-clock/reset signal of rob.
// Modports: master - the pipeline side (drives dispatch, CDB, operand queries)
//           slave  - the reorder buffer itself
// Signals : dispatch_valid/ready/rd_addr/rob_idx, cdb_valid/rob_idx/data,
//           commit_valid/regf_we/rd_addr/data/rob_idx, empty, full.
// Macro   : ROB_FWD_EN adds rs1/rs2 operand read ports.
interface rob_if;
   import rob_pkg::*;

   logic                     dispatch_valid;
   logic                     dispatch_ready;
   logic [RD_WIDTH-1:0]      dispatch_rd_addr;
   logic [ROB_IDX_WIDTH-1:0] dispatch_rob_idx;

   logic                     cdb_valid;
   logic [ROB_IDX_WIDTH-1:0] cdb_rob_idx;
   logic [XLEN-1:0]          cdb_data;

   logic                     commit_valid;
   logic                     commit_regf_we;
   logic [RD_WIDTH-1:0]      commit_rd_addr;
   logic [XLEN-1:0]          commit_data;
   logic [ROB_IDX_WIDTH-1:0] commit_rob_idx;

   logic                     empty;
   logic                     full;

`ifdef ROB_FWD_EN
   logic [ROB_IDX_WIDTH-1:0] rs1_rob_idx;
   logic [ROB_IDX_WIDTH-1:0] rs2_rob_idx;
   logic                     rs1_fwd_ready;
   logic                     rs2_fwd_ready;
   logic [XLEN-1:0]          rs1_fwd_data;
   logic [XLEN-1:0]          rs2_fwd_data;

   modport master (
      output dispatch_valid, dispatch_rd_addr, cdb_valid, cdb_rob_idx, cdb_data,
             rs1_rob_idx, rs2_rob_idx,
      input  dispatch_ready, dispatch_rob_idx, commit_valid, commit_regf_we,
             commit_rd_addr, commit_data, commit_rob_idx, empty, full,
             rs1_fwd_ready, rs2_fwd_ready, rs1_fwd_data, rs2_fwd_data
   );

   modport slave (
      input  dispatch_valid, dispatch_rd_addr, cdb_valid, cdb_rob_idx, cdb_data,
             rs1_rob_idx, rs2_rob_idx,
      output dispatch_ready, dispatch_rob_idx, commit_valid, commit_regf_we,
             commit_rd_addr, commit_data, commit_rob_idx, empty, full,
             rs1_fwd_ready, rs2_fwd_ready, rs1_fwd_data, rs2_fwd_data
   );
`else
   modport master (
      output dispatch_valid, dispatch_rd_addr, cdb_valid, cdb_rob_idx, cdb_data,
      input  dispatch_ready, dispatch_rob_idx, commit_valid, commit_regf_we,
             commit_rd_addr, commit_data, commit_rob_idx, empty, full
   );

   modport slave (
      input  dispatch_valid, dispatch_rd_addr, cdb_valid, cdb_rob_idx, cdb_data,
      output dispatch_ready, dispatch_rob_idx, commit_valid, commit_regf_we,
             commit_rd_addr, commit_data, commit_rob_idx, empty, full
   );
`endif

endinterface

// File: rtl/rob_ptr.sv
// rtl/rob_ptr.sv - wrapping head/tail pointer of the reorder buffer
//
// Purpose: index register with a wrap bit; incrementing past DEPTH-1 returns
//          the index to 0 and toggles the wrap bit.
// Ports  : clk, rst (async, active high), inc (advance at posedge),
//          ptr (current pointer).
module rob_ptr
   import rob_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     inc,
   output rob_ptr_t ptr
);

   // wrap is the MSB of the packed struct, so a plain +1 carries into it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= rob_ptr_t'(ptr + 1'b1);
      end
   end

endmodule

// File: rtl/rob.sv
// rtl/rob.sv - circular reorder buffer with in-order single-entry retirement
//
// Purpose: allocates an index per dispatched instruction, captures CDB
//          results, and retires the head entry once it is done.
// Ports  : clk, rst (async, active high), bus (rob_if.slave): dispatch
//          handshake and allocated index, CDB completion, commit port to
//          the register file / rename table, empty / full status.
// Macro  : ROB_FWD_EN adds combinational rs1/rs2 operand forwarding with
//          same-cycle CDB bypass.
module rob
   import rob_pkg::*;
(
   input  logic clk,
   input  logic rst,
   rob_if.slave bus
);

   rob_entry_t entries [DEPTH];
   rob_ptr_t   head;
   rob_ptr_t   tail;
   rob_entry_t head_entry;
   logic       do_alloc;
   logic       do_complete;
   logic       do_commit;

   assign head_entry = entries[head.idx];

   assign bus.full             = (head.idx == tail.idx) && (head.wrap != tail.wrap);
   assign bus.empty            = (head == tail);
   assign bus.dispatch_ready   = ~bus.full;
   assign bus.dispatch_rob_idx = tail.idx;

   // Readiness uses the pre-edge full flag, so a full buffer refuses
   // dispatch even in the cycle its head retires.
   assign do_alloc    = bus.dispatch_valid && bus.dispatch_ready;
   // Completions aimed at unallocated entries are dropped.
   assign do_complete = bus.cdb_valid && entries[bus.cdb_rob_idx].valid;
   assign do_commit   = head_entry.valid && head_entry.done;

   assign bus.commit_valid   = do_commit;
   assign bus.commit_regf_we = do_commit && (head_entry.rd != '0);
   assign bus.commit_rd_addr = head_entry.rd;
   assign bus.commit_data    = head_entry.data;
   assign bus.commit_rob_idx = head.idx;

   rob_ptr u_head (
      .clk (clk),
      .rst (rst),
      .inc (do_commit),
      .ptr (head)
   );

   rob_ptr u_tail (
      .clk (clk),
      .rst (rst),
      .inc (do_alloc),
      .ptr (tail)
   );

   // Allocate, complete and retire always target distinct entries: the
   // allocated slot is invalid (so neither completes nor retires), and a
   // retiring head is already done so it never takes a completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         if (do_alloc) begin
            entries[tail.idx].valid <= 1'b1;
            entries[tail.idx].done  <= 1'b0;
            entries[tail.idx].rd    <= bus.dispatch_rd_addr;
            entries[tail.idx].data  <= '0;
         end
         if (do_complete) begin
            entries[bus.cdb_rob_idx].done <= 1'b1;
            entries[bus.cdb_rob_idx].data <= bus.cdb_data;
         end
         if (do_commit) begin
            entries[head.idx].valid <= 1'b0;
         end
      end
   end

   // A result cannot exist for an instruction that is only now being allocated.
   a_no_cdb_to_alloc : assert property (@(posedge clk) disable iff (rst)
      !(do_alloc && bus.cdb_valid && (bus.cdb_rob_idx == tail.idx)));

`ifdef ROB_FWD_EN
   rob_entry_t rs1_entry;
   rob_entry_t rs2_entry;
   logic       rs1_byp;
   logic       rs2_byp;

   assign rs1_entry = entries[bus.rs1_rob_idx];
   assign rs2_entry = entries[bus.rs2_rob_idx];

   assign rs1_byp = do_complete && (bus.cdb_rob_idx == bus.rs1_rob_idx);
   assign rs2_byp = do_complete && (bus.cdb_rob_idx == bus.rs2_rob_idx);

   assign bus.rs1_fwd_ready = rs1_byp || (rs1_entry.valid && rs1_entry.done);
   assign bus.rs2_fwd_ready = rs2_byp || (rs2_entry.valid && rs2_entry.done);
   assign bus.rs1_fwd_data  = rs1_byp ? bus.cdb_data : rs1_entry.data;
   assign bus.rs2_fwd_data  = rs2_byp ? bus.cdb_data : rs2_entry.data;
`endif

endmodule

// File: tb/tb_rob.sv
// tb/tb_rob.sv - scoreboard testbench for the reorder buffer
module tb_rob;
   import rob_pkg::*;

   typedef struct {
      logic [4:0] idx;
      logic [4:0] rd;
   } exp_t;

   logic clk;
   logic rst;
   rob_if bus ();

   rob dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   exp_t        sb[$];
   logic [31:0] model_data [32];
   logic [5:0]  tb_tail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Commit monitor: every retirement must match the oldest outstanding
   // dispatch, with the data the bench last broadcast for that index.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.commit_valid) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_commit idx=%0d rd=%0d expected no commit",
                     bus.commit_rob_idx, bus.commit_rd_addr);
         end else begin
            e = sb.pop_front();
            if (bus.commit_rob_idx !== e.idx || bus.commit_rd_addr !== e.rd ||
                bus.commit_data !== model_data[e.idx] ||
                bus.commit_regf_we !== (e.rd != 5'd0)) begin
               n_fail++;
               $display("FAIL sb_commit got idx=%0d rd=%0d data=%h we=%b expected idx=%0d rd=%0d data=%h we=%b",
                        bus.commit_rob_idx, bus.commit_rd_addr, bus.commit_data, bus.commit_regf_we,
                        e.idx, e.rd, model_data[e.idx], (e.rd != 5'd0));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic dispatch(input logic [4:0] rd);
      exp_t e;
      bus.dispatch_valid   = 1'b1;
      bus.dispatch_rd_addr = rd;
      e.idx = tb_tail[4:0];
      e.rd  = rd;
      sb.push_back(e);
      tb_tail = tb_tail + 6'd1;
      tick();
      bus.dispatch_valid = 1'b0;
   endtask

   task automatic cdb(input logic [4:0] idx, input logic [31:0] d, input bit live);
      bus.cdb_valid   = 1'b1;
      bus.cdb_rob_idx = idx;
      bus.cdb_data    = d;
      if (live) model_data[idx] = d;
      tick();
      bus.cdb_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #10;
      rst = 1'b0;
      sb.delete();
      tb_tail = '0;
      tick();
   endtask

   task automatic test_reset();
      n_checks++;
      if (bus.dispatch_ready !== 1'b1 || bus.dispatch_rob_idx !== 5'd0 || bus.empty !== 1'b1 ||
          bus.full !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_status ready=%b idx=%0d empty=%b full=%b expected 1 0 1 0",
                  bus.dispatch_ready, bus.dispatch_rob_idx, bus.empty, bus.full);
      end
      n_checks++;
      if (bus.commit_valid !== 1'b0 || bus.commit_regf_we !== 1'b0 || bus.commit_data !== 32'd0 ||
          bus.commit_rd_addr !== 5'd0 || bus.commit_rob_idx !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_commit valid=%b we=%b data=%h rd=%0d idx=%0d expected all zero",
                  bus.commit_valid, bus.commit_regf_we, bus.commit_data, bus.commit_rd_addr,
                  bus.commit_rob_idx);
      end
   endtask

   task automatic test_in_order();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (bus.dispatch_rob_idx !== 5'(i)) begin
            n_fail++;
            $display("FAIL inorder_alloc_idx got %0d expected %0d", bus.dispatch_rob_idx, i);
         end
         dispatch(5'(i + 1));
      end
      cdb(5'd1, 32'h0000_0111, 1'b1);
      n_checks++;
      if (bus.commit_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL inorder_hold_head got commit_valid=%b expected 0", bus.commit_valid);
      end
      cdb(5'd0, 32'h0000_0100, 1'b1);
      n_checks++;
      if (bus.commit_valid !== 1'b1 || bus.commit_rob_idx !== 5'd0) begin
         n_fail++;
         $display("FAIL inorder_commit0 got valid=%b idx=%0d expected 1 0",
                  bus.commit_valid, bus.commit_rob_idx);
      end
      tick();
      n_checks++;
      if (bus.commit_valid !== 1'b1 || bus.commit_rob_idx !== 5'd1) begin
         n_fail++;
         $display("FAIL inorder_commit1 got valid=%b idx=%0d expected 1 1",
                  bus.commit_valid, bus.commit_rob_idx);
      end
      tick();
      n_checks++;
      if (bus.commit_valid !== 1'b0 || bus.empty !== 1'b0) begin
         n_fail++;
         $display("FAIL inorder_idx2_held got valid=%b empty=%b expected 0 0",
                  bus.commit_valid, bus.empty);
      end
      cdb(5'd2, 32'h0000_0222, 1'b1);
      tick();
      n_checks++;
      if (bus.empty !== 1'b1) begin
         n_fail++;
         $display("FAIL inorder_drained got empty=%b expected 1", bus.empty);
      end
   endtask

   task automatic test_full_wrap();
      pulse_reset();
      for (int i = 0; i < 32; i++) begin
         n_checks++;
         if (bus.dispatch_rob_idx !== 5'(i) || bus.dispatch_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_alloc got idx=%0d ready=%b expected %0d 1",
                     bus.dispatch_rob_idx, bus.dispatch_ready, i);
         end
         dispatch(5'((i % 31) + 1));
      end
      n_checks++;
      if (bus.full !== 1'b1 || bus.dispatch_ready !== 1'b0 || bus.empty !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_full got full=%b ready=%b empty=%b expected 1 0 0",
                  bus.full, bus.dispatch_ready, bus.empty);
      end
      cdb(5'd0, 32'h0000_00A0, 1'b1);
      // Dispatch offered in the same cycle the head retires: must be refused.
      bus.dispatch_valid   = 1'b1;
      bus.dispatch_rd_addr = 5'd9;
      #1;
      n_checks++;
      if (bus.commit_valid !== 1'b1 || bus.dispatch_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_commit_refuse got commit_valid=%b ready=%b expected 1 0",
                  bus.commit_valid, bus.dispatch_ready);
      end
      tick();
      bus.dispatch_valid = 1'b0;
      n_checks++;
      if (bus.full !== 1'b0 || bus.dispatch_ready !== 1'b1 || bus.dispatch_rob_idx !== 5'd0) begin
         n_fail++;
         $display("FAIL wrap_alloc got full=%b ready=%b idx=%0d expected 0 1 0",
                  bus.full, bus.dispatch_ready, bus.dispatch_rob_idx);
      end
      dispatch(5'd9);
      n_checks++;
      if (bus.full !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_refull got full=%b expected 1", bus.full);
      end
      for (int k = 1; k <= 32; k++) begin
         cdb(5'(k), 32'hC000_0000 + 32'(k), 1'b1);
      end
      tick();
      tick();
      n_checks++;
      if (bus.empty !== 1'b1 || bus.dispatch_rob_idx !== 5'd1) begin
         n_fail++;
         $display("FAIL wrap_drained got empty=%b idx=%0d expected 1 1",
                  bus.empty, bus.dispatch_rob_idx);
      end
   endtask

   task automatic test_rd_zero();
      logic [4:0] idx;
      idx = tb_tail[4:0];
      dispatch(5'd0);
      cdb(idx, 32'hDEAD_BEEF, 1'b1);
      n_checks++;
      if (bus.commit_valid !== 1'b1 || bus.commit_regf_we !== 1'b0 ||
          bus.commit_data !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL rd_zero got valid=%b we=%b data=%h expected 1 0 deadbeef",
                  bus.commit_valid, bus.commit_regf_we, bus.commit_data);
      end
      tick();
   endtask

   task automatic test_cdb_invalid();
      logic [4:0] idx_before;
      idx_before = bus.dispatch_rob_idx;
      cdb(5'd7, 32'h7777_7777, 1'b0);
      tick();
      n_checks++;
      if (bus.empty !== 1'b1 || bus.commit_valid !== 1'b0 || bus.dispatch_rob_idx !== idx_before) begin
         n_fail++;
         $display("FAIL cdb_invalid got empty=%b valid=%b idx=%0d expected 1 0 %0d",
                  bus.empty, bus.commit_valid, bus.dispatch_rob_idx, idx_before);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) dispatch(5'(i + 11));
      cdb(5'd3, 32'h3333_3333, 1'b1);
      #2;
      rst = 1'b1;
      #2;
      n_checks++;
      if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.dispatch_ready !== 1'b1 ||
          bus.dispatch_rob_idx !== 5'd0 || bus.commit_valid !== 1'b0 ||
          bus.commit_rob_idx !== 5'd0 || bus.commit_rd_addr !== 5'd0 || bus.commit_data !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_mid got empty=%b full=%b ready=%b idx=%0d cv=%b cidx=%0d crd=%0d cdata=%h expected 1 0 1 0 0 0 0 0",
                  bus.empty, bus.full, bus.dispatch_ready, bus.dispatch_rob_idx, bus.commit_valid,
                  bus.commit_rob_idx, bus.commit_rd_addr, bus.commit_data);
      end
      sb.delete();
      tb_tail = '0;
      #2;
      rst = 1'b0;
      tick();
      n_checks++;
      if (bus.dispatch_rob_idx !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_mid_idx got %0d expected 0", bus.dispatch_rob_idx);
      end
      dispatch(5'd4);
      n_checks++;
      if (bus.commit_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_fresh got commit_valid=%b expected 0", bus.commit_valid);
      end
      cdb(5'd0, 32'h0000_1234, 1'b1);
      tick();
      n_checks++;
      if (bus.empty !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_drain got empty=%b expected 1", bus.empty);
      end
   endtask

`ifdef ROB_FWD_EN
   task automatic test_fwd();
      for (int i = 0; i < 4; i++) dispatch(5'(i + 20));
      bus.rs1_rob_idx = 5'd4;
      bus.rs2_rob_idx = 5'd3;
      bus.cdb_valid   = 1'b1;
      bus.cdb_rob_idx = 5'd4;
      bus.cdb_data    = 32'h55;
      model_data[4]   = 32'h55;
      #1;
      n_checks++;
      if (bus.rs1_fwd_ready !== 1'b1 || bus.rs1_fwd_data !== 32'h55 || bus.rs2_fwd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL fwd_bypass got rs1_ready=%b rs1_data=%h rs2_ready=%b expected 1 55 0",
                  bus.rs1_fwd_ready, bus.rs1_fwd_data, bus.rs2_fwd_ready);
      end
      tick();
      bus.cdb_valid = 1'b0;
      for (int k = 1; k <= 3; k++) cdb(5'(k), 32'hF000_0000 + 32'(k), 1'b1);
      tick();
      tick();
   endtask
`endif

   initial begin
      rst                  = 1'b1;
      bus.dispatch_valid   = 1'b0;
      bus.dispatch_rd_addr = '0;
      bus.cdb_valid        = 1'b0;
      bus.cdb_rob_idx      = '0;
      bus.cdb_data         = '0;
`ifdef ROB_FWD_EN
      bus.rs1_rob_idx      = '0;
      bus.rs2_rob_idx      = '0;
`endif
      tb_tail              = '0;
      for (int i = 0; i < 32; i++) model_data[i] = '0;
      #3;
      test_reset();
      #10;
      rst = 1'b0;
      tick();
      test_in_order();
      test_full_wrap();
      test_rd_zero();
      test_cdb_invalid();
      test_reset_mid();
`ifdef ROB_FWD_EN
      test_fwd();
`endif
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover got %0d outstanding expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
